// File: rtl/set_assoc_cache.sv
// set_assoc_cache: 2-way set-associative, write-through/no-write-allocate cache
// with one LRU bit per set and saturating hit/miss statistics.
module set_assoc_cache #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 2,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_hit,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);
    localparam int SETS  = 2 ** INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, MEM_WR, RESP} state_t;
    state_t state, state_nx;

    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               r_hit;
    logic [DATA_W-1:0]  r_data;
    logic [SETS-1:0]    valid0, valid1, lru;
    logic [TAG_W-1:0]   tag0 [SETS];
    logic [TAG_W-1:0]   tag1 [SETS];
    logic [DATA_W-1:0]  data0 [SETS];
    logic [DATA_W-1:0]  data1 [SETS];
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic               hit0, hit1, hit, victim, fill, wr_hit;

    assign idx       = addr_q[INDEX_W-1:0];
    assign tag       = addr_q[ADDR_W-1:INDEX_W];
    assign hit0      = valid0[idx] && tag0[idx] == tag;
    assign hit1      = valid1[idx] && tag1[idx] == tag;
    assign hit       = hit0 || hit1;
    assign victim    = !valid0[idx] ? 1'b0 : !valid1[idx] ? 1'b1 : lru[idx];
    assign fill      = state == MEM_RD && mem_ack;
    assign wr_hit    = state == LOOKUP && we_q && hit;
    assign mem_addr  = addr_q;
    assign mem_wdata = mem_we ? wdata_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        req_ready = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                state_nx  = req_valid ? LOOKUP : IDLE;
            end
            LOOKUP: state_nx = we_q ? MEM_WR : hit ? RESP : MEM_RD;
            MEM_RD: begin
                mem_req  = 1'b1;
                state_nx = mem_ack ? RESP : MEM_RD;
            end
            MEM_WR: begin
                mem_req  = 1'b1;
                mem_we   = 1'b1;
                state_nx = mem_ack ? RESP : MEM_WR;
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Control bits and statistics; the response is registered out of RESP,
    // so it appears the cycle after RESP while the FSM is already back in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            r_hit      <= 1'b0;
            r_data     <= '0;
            valid0     <= '0;
            valid1     <= '0;
            lru        <= '0;
            resp_valid <= 1'b0;
            resp_hit   <= 1'b0;
            resp_rdata <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            resp_valid <= state == RESP;
            if (state == IDLE && req_valid) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == LOOKUP) begin
                r_hit  <= hit;
                r_data <= we_q ? '0 : hit0 ? data0[idx] : data1[idx];
                if (hit) lru[idx] <= hit0;
            end
            if (fill) begin
                if (victim) valid1[idx] <= 1'b1;
                else        valid0[idx] <= 1'b1;
                lru[idx] <= !victim;
                r_data   <= mem_rdata;
            end
            if (state == RESP) begin
                resp_hit   <= r_hit;
                resp_rdata <= r_data;
                if (r_hit && hit_count != '1)   hit_count  <= hit_count + CNT_W'(1);
                if (!r_hit && miss_count != '1) miss_count <= miss_count + CNT_W'(1);
            end
        end
    end

    // Tag/data arrays carry no reset; valid bits alone qualify their contents.
    always_ff @(posedge clk) begin
        if (fill) begin
            if (victim) begin
                tag1[idx]  <= tag;
                data1[idx] <= mem_rdata;
            end else begin
                tag0[idx]  <= tag;
                data0[idx] <= mem_rdata;
            end
        end
        if (wr_hit) begin
            if (hit0) data0[idx] <= wdata_q;
            else      data1[idx] <= wdata_q;
        end
    end
endmodule
